// File: rtl/ibuf_beat_shuffler.sv
// DDR beat to IBUF bank shuffler with valid/ready skid pair, per-tile mode and last tagging.
// Optional stall counter is enabled by defining IBUF_SHUFFLER_STALL_CNT_EN.
module ibuf_beat_shuffler #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int RATIO         = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH),
    parameter int BEAT_CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_mode,
    input  logic [BEAT_CNT_W-1:0]    cfg_num_beats,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DDR_BANDWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DDR_BANDWIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     tile_done,
`ifdef IBUF_SHUFFLER_STALL_CNT_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic                     busy
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [BEAT_CNT_W-1:0]    r_beat_cnt, w_cnt_nxt;
    logic [BEAT_CNT_W-1:0]    r_num_beats, w_num_nxt, w_num_cfg;
    logic                     r_mode, w_mode_nxt, w_beat_mode;
    logic                     w_last;
    logic                     w_accept, w_consume;
    logic [DDR_BANDWIDTH-1:0] w_trans, w_beat;

    logic                     r_out_valid, r_out_last;
    logic [DDR_BANDWIDTH-1:0] r_out_data;
    logic                     r_skid_valid, r_skid_last;
    logic [DDR_BANDWIDTH-1:0] r_skid_data;
    logic                     r_tile_done;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign tile_done = r_tile_done;
    assign busy      = (r_state == S_ACTIVE) || r_out_valid || r_skid_valid;

    assign w_accept  = in_valid && !r_skid_valid;
    assign w_consume = r_out_valid && out_ready;

    always_comb begin
        w_trans = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            for (int i = 0; i < RATIO; i++) begin
                w_trans[(j*RATIO+i)*DATA_WIDTH +: DATA_WIDTH] =
                    in_data[(i*NUM_BANKS+j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_num_cfg = (cfg_num_beats == '0) ? BEAT_CNT_W'(1) : cfg_num_beats;

    // Mode for the beat in flight: config applies directly on the first beat of a tile.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_num_nxt   = r_num_beats;
        w_mode_nxt  = r_mode;
        w_last      = 1'b0;
        w_beat_mode = (r_state == S_IDLE) ? cfg_mode : r_mode;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    w_mode_nxt  = cfg_mode;
                    w_num_nxt   = w_num_cfg;
                    w_cnt_nxt   = BEAT_CNT_W'(1);
                    w_last      = (w_num_cfg == BEAT_CNT_W'(1));
                    w_state_nxt = w_last ? S_IDLE : S_ACTIVE;
                end
                S_ACTIVE: begin
                    w_cnt_nxt = r_beat_cnt + BEAT_CNT_W'(1);
                    w_last    = (w_cnt_nxt == r_num_beats);
                    if (w_last) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_beat = w_beat_mode ? w_trans : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_num_beats <= '0;
            r_mode      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_cnt_nxt;
            r_num_beats <= w_num_nxt;
            r_mode      <= w_mode_nxt;
        end
    end

    // Skid is only ever occupied while the main register holds a stalled beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= '0;
            r_tile_done  <= 1'b0;
        end else begin
            r_tile_done <= w_consume && r_out_last;
            if (!r_out_valid || out_ready) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_beat;
                    r_out_last  <= w_last;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_beat;
                r_skid_last  <= w_last;
            end
        end
    end

`ifdef IBUF_SHUFFLER_STALL_CNT_EN
    logic [31:0] r_stall_cycles;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_out_valid && !out_ready && r_stall_cycles != 32'hFFFF_FFFF) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ibuf_beat_shuffler.md
# ibuf_beat_shuffler

Pipelined, flow-controlled successor to the combinational IBUF lane shuffler. It sits between the DDR read-data path and the input-buffer (IBUF) bank write port. It reorders each DDR beat so every IBUF bank receives its own contiguous RATIO-element group. It adds a valid/ready handshake with full-throughput skid buffering, a per-tile mode select (transpose or passthrough), and tile-boundary tagging.

## Interface
- DDR_BANDWIDTH, 512, beat width in bits
- NUM_BANKS, 8, IBUF banks per beat
- DATA_WIDTH, 8, element width in bits
- RATIO, DDR_BANDWIDTH/(NUM_BANKS*DATA_WIDTH), elements per bank per beat; DDR_BANDWIDTH must equal NUM_BANKS*RATIO*DATA_WIDTH
- BEAT_CNT_W, 16, width of the tile beat counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- cfg_mode  in  1  0 = passthrough, 1 = bank transpose; sampled at tile start
- cfg_num_beats  in  BEAT_CNT_W  beats per tile; sampled at tile start; 0 treated as 1
- in_valid  in  1  input beat valid
- in_ready  out  1  input may be accepted
- in_data  in  DDR_BANDWIDTH  DDR beat
- out_valid  out  1  shuffled beat valid
- out_ready  in  1  IBUF write side accepts
- out_data  out  DDR_BANDWIDTH  shuffled beat
- out_last  out  1  beat is the final beat of the tile
- tile_done  out  1  one-cycle pulse when the last beat is accepted at the output
- busy  out  1  tile in progress or data held in the pipeline
- stall_cycles  out  32  present only with IBUF_SHUFFLER_STALL_CNT_EN

## Operation
- Element e of in_data occupies bits [e*DATA_WIDTH +: DATA_WIDTH], for e in 0..NUM_BANKS*RATIO-1.
- Transpose mode: output element (j*RATIO+i) = input element (i*NUM_BANKS+j), for bank j and slot i. Bank j therefore owns out_data bits [j*RATIO*DATA_WIDTH +: RATIO*DATA_WIDTH].
- Passthrough mode: out_data = in_data.
- FSM states:
  - IDLE: the first accepted beat latches cfg_mode and cfg_num_beats (0 becomes 1), loads beat_cnt = 1, and moves to ACTIVE. If the latched count is 1, the FSM stays in IDLE and that beat carries last.
  - ACTIVE: each accepted beat increments beat_cnt. The beat where beat_cnt equals the latched count carries last and returns the FSM to IDLE.
  - cfg_* changes while in ACTIVE are ignored.
- The shuffle is applied combinationally before the stage register, so the mode travels with each beat. Back-to-back tiles with different modes are allowed with no gap.
- Buffering is a two-entry skid pair: a main output register plus a skid register.
  - in_ready = !skid_valid, driven from a register.
  - A beat accepted while out_valid && !out_ready goes into the skid register.
  - When the main register drains, skid contents move into it.
- busy = (state == ACTIVE) || out_valid || skid_valid.
- tile_done = out_valid && out_ready && out_last, registered, so it asserts one cycle after the handshake.

## Timing
- Latency: a beat accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset values: out_valid=0, in_ready=1, out_last=0, tile_done=0, busy=0, out_data=0, stall_cycles=0, FSM=IDLE, beat_cnt=0.
- Reset asserted mid-tile discards all buffered beats and the counter immediately. No tile_done is issued for the aborted tile.
- out_valid/out_data/out_last hold stable while out_valid && !out_ready.
- A beat is accepted on in_valid && in_ready. A beat is consumed on out_valid && out_ready.
- Simultaneous accept and consume with the skid empty: the main register is overwritten in the same cycle and in_ready stays 1.
- beat_cnt never wraps within a tile. The maximum tile is 2^BEAT_CNT_W−1 beats.

## Configuration
- IBUF_SHUFFLER_STALL_CNT_EN defined:
  - stall_cycles port exists.
  - It counts cycles with out_valid && !out_ready, saturating at 0xFFFFFFFF.
  - It is cleared only by reset.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Transpose: defaults, cfg_mode=1, cfg_num_beats=1, in_data byte e = e. Response 1 cycle later: out byte 1 = 0x08, out byte 8 = 0x01, out byte 63 = 0x3F; out_last=1; tile_done pulses the cycle after the output handshake.
- Passthrough: cfg_mode=0, 4-beat tile of random data. out_data matches in_data exactly; out_last is set only on beat 4; exactly one tile_done pulse.
- Backpressure: 8-beat tile with out_ready=0 for 3 cycles mid-stream. in_ready drops after 2 buffered beats; no beat is lost or duplicated; order is preserved; stall_cycles increments by 3 (macro defined).
- Mode switch: back-to-back tiles, num_beats=2 with mode 1, then num_beats=2 with mode 0, no idle gap. Beats 1–2 are transposed and beats 3–4 are passed through; out_last is set on beats 2 and 4.
- Reset mid-tile: assert reset after 3 of 10 beats. All outputs return to reset values the same cycle; the next tile starts clean with beat_cnt=1.
- cfg_num_beats=0: a single beat carries out_last=1 and the FSM remains in IDLE.
